branch_predictor: RTL
=====================

// Module: branch_predictor
// PURPOSE
//  Dynamic branch predictor feeding the IF stage. Direct-mapped BTB with a 2-bit saturating counter per entry.
//  The fetch PC is looked up combinationally: IF gets pred_taken/pred_target in the same cycle.
//  Branches resolved in MEM write back outcome/target through the update port. Also keeps branch/mispredict stats.
// PARAMETERS
//  ENTRIES   64     BTB entries, power of 2; IDX_W = $clog2(ENTRIES) (localparam)
//  TAG_W     6      tag bits; IDX_W+TAG_W = 12 covers pc[13:2] (4K-word instr memory)
//  INIT_CTR  2'b01  counter value written by the clear sweep (weakly not-taken)
// PORTS
//  clk              in   1   clock; one clock domain
//  rst              in   1   reset, synchronous, active-high
//  ce               in   1   clock enable; gates updates and stats, not the clear sweep
//  lu_pc            in   32  fetch PC to look up (bits [1:0] ignored)
//  pred_taken       out  1   predict taken for lu_pc
//  pred_target      out  32  predicted next PC
//  up_valid         in   1   resolution record valid this cycle
//  up_pc            in   32  PC of the resolved instruction
//  up_is_branch     in   1   resolved instruction is a conditional branch
//  up_taken         in   1   actual outcome
//  up_target        in   32  actual taken target
//  up_mispredict    in   1   MEM flagged a misprediction for this branch
//  ready            out  1   clear sweep done; predictions are live
//  stat_branches    out  32  accepted branch updates, saturating
//  stat_mispredicts out  32  accepted updates with up_mispredict=1, saturating
// BEHAVIOUR
//  Indexing: idx = pc[IDX_W+1:2]; tag = pc[IDX_W+TAG_W+1:IDX_W+2]. Entry fields: {valid, tag, ctr[1:0], target[31:0]}.
//  FSM states CLEAR and RUN:
//   - rst=1 at a clock edge -> state=CLEAR, clr_idx=0, stats=0. This applies in any state, including mid-sweep (sweep restarts at 0).
//   - CLEAR: each edge writes entry[clr_idx] with valid=0 and ctr=INIT_CTR, then increments clr_idx.
//     After the write to ENTRIES-1 -> RUN. This takes exactly ENTRIES edges and ignores ce.
//   - RUN: stays in RUN until rst.
//  ready = (state==RUN), combinational from state.
//  Lookup, combinational: hit = valid && tag match.
//   - pred_taken = ready && hit && ctr[1].
//   - pred_target = pred_taken ? target : lu_pc+32'd4 (mod 2^32).
//   - Reset values: ready=0, pred_taken=0, pred_target=lu_pc+4, stats=0.
//  Update is accepted when ready && ce && up_valid && up_is_branch. In CLEAR or with ce=0 the update is dropped silently.
//   - up hit, taken: ctr = sat_inc(ctr) (11 stays 11); target = up_target.
//   - up hit, not taken: ctr = sat_dec(ctr) (00 stays 00); target unchanged.
//   - up miss, taken: allocate/overwrite with valid=1, new tag, ctr=2'b10, target=up_target.
//   - up miss, not taken: no change.
//   - up_valid with up_is_branch=0: no change, no stat increment.
//  Same-cycle lookup and update to the same idx: the lookup sees pre-update contents (write at edge, visible next cycle).
//  Stats: stat_branches += 1 per accepted update; stat_mispredicts += 1 if also up_mispredict. Both hold at 32'hFFFF_FFFF.
//  Latency: prediction 0 cycles; an update is visible to lookups 1 cycle after its edge.
// STRUCTURE
//  Package bpred_pkg holds:
//   - state enum {CLEAR, RUN}
//   - counter encodings SNT=00, WNT=01, WT=10, ST=11
//   - functions sat_inc/sat_dec (2-bit) and sat_add32
//   - entry struct typedef
//  Sub-module bpred_table holds the storage array:
//   - one combinational read port (lookup), one combinational read port (update hit check), one write port
//   - clear writes share the write port, muxed by FSM state
//  Top level holds the FSM, update logic and stats.
// TESTING
//  1. rst=1 one cycle, then 0 -> ready=0 for 64 edges, ready=1 after the 64th; pred_taken=0 and pred_target=lu_pc+4 throughout.
//  2. After ready: update pc=0x100 taken target=0x40 -> next cycle lu_pc=0x100 gives pred_taken=1, pred_target=0x40.
//  3. Same entry: 3 not-taken updates -> ctr 10->01->00->00; pred_taken=0 after the first; 2 taken updates -> ctr=10, pred_taken=1.
//  4. Aliasing: pc=0x100 taken tgt 0x40, then pc=0x1100 (same idx, other tag) taken tgt 0x80 -> lookup 0x100 misses (pred 0x104), lookup 0x1100 gives 0x80.
//  5. Same-cycle lookup+update on pc=0x200 (empty entry, update taken) -> pred_taken=0 that cycle, 1 the next; updates with ce=0 or up_is_branch=0 leave the entry and stats unchanged.
//  6. rst pulse at clear index 30 -> sweep restarts and ready rises 64 edges later; after 10 updates with 3 mispredicts -> stat_branches=10, stat_mispredicts=3; with stats preloaded to 0xFFFF_FFFF, stat_branches holds at 0xFFFF_FFFF.

Source files
------------

// File: rtl/bpred_pkg.sv
// bpred_pkg: shared types, counter encodings and saturating helpers for the branch predictor
package bpred_pkg;
  localparam int BP_TAG_W = 6;
  typedef enum logic {CLEAR, RUN} state_e;
  localparam logic [1:0] SNT = 2'b00;
  localparam logic [1:0] WNT = 2'b01;
  localparam logic [1:0] WT  = 2'b10;
  localparam logic [1:0] ST  = 2'b11;
  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [1:0]          ctr;
    logic [31:0]         target;
  } entry_t;
  function automatic logic [1:0] sat_inc(input logic [1:0] c);
    return (c == ST) ? ST : c + 2'd1;
  endfunction
  function automatic logic [1:0] sat_dec(input logic [1:0] c);
    return (c == SNT) ? SNT : c - 2'd1;
  endfunction
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[32] ? 32'hFFFF_FFFF : s[31:0];
  endfunction
endpackage

// File: rtl/bpred_table.sv
// bpred_table: BTB storage; clk, lookup read port (lu_idx->lu_entry), update-hit read port (up_idx->up_entry), one write port (we/wr_idx/wr_entry)
module bpred_table import bpred_pkg::*; #(
  parameter int ENTRIES = 64,
  localparam int IDX_W = $clog2(ENTRIES)
) (
  input  logic             clk,
  input  logic [IDX_W-1:0] lu_idx,
  output entry_t           lu_entry,
  input  logic [IDX_W-1:0] up_idx,
  output entry_t           up_entry,
  input  logic             we,
  input  logic [IDX_W-1:0] wr_idx,
  input  entry_t           wr_entry
);
  entry_t mem_q [ENTRIES];
  always_ff @(posedge clk)
    if (we) mem_q[wr_idx] <= wr_entry;
  assign lu_entry = mem_q[lu_idx];
  assign up_entry = mem_q[up_idx];
endmodule

// File: rtl/branch_predictor.sv
// branch_predictor: BTB + 2-bit counter predictor; clk/rst/ce, lookup lu_pc->pred_taken/pred_target, update up_*, ready, saturating stats
module branch_predictor import bpred_pkg::*; #(
  parameter int         ENTRIES  = 64,
  parameter int         TAG_W    = BP_TAG_W,
  parameter logic [1:0] INIT_CTR = WNT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ce,
  input  logic [31:0] lu_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        up_valid,
  input  logic [31:0] up_pc,
  input  logic        up_is_branch,
  input  logic        up_taken,
  input  logic [31:0] up_target,
  input  logic        up_mispredict,
  output logic        ready,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);
  localparam int IDX_W = $clog2(ENTRIES);
  state_e state_q, state_d;
  logic [IDX_W-1:0] clr_idx_q, clr_idx_d, lu_idx, up_idx, wr_idx;
  logic [TAG_W-1:0] lu_tag, up_tag;
  logic [31:0] stat_branches_q, stat_branches_d, stat_mispredicts_q, stat_mispredicts_d;
  entry_t lu_entry, up_entry, wr_entry, upd_entry;
  logic clearing, up_hit, acc, we, unused_pc;
  assign lu_idx = lu_pc[IDX_W+1:2];
  assign up_idx = up_pc[IDX_W+1:2];
  assign lu_tag = lu_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign up_tag = up_pc[IDX_W+TAG_W+1:IDX_W+2];
  assign unused_pc = ^{up_pc[31:IDX_W+TAG_W+2], up_pc[1:0]};
  assign stat_branches = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;
  bpred_table #(.ENTRIES(ENTRIES)) u_table (
    .clk(clk), .lu_idx(lu_idx), .lu_entry(lu_entry), .up_idx(up_idx), .up_entry(up_entry),
    .we(we), .wr_idx(wr_idx), .wr_entry(wr_entry)
  );
  always_comb begin
    clearing = state_q == CLEAR;
    ready = !clearing;
    up_hit = up_entry.valid && up_entry.tag == up_tag;
    acc = ready && ce && up_valid && up_is_branch;
    upd_entry = up_hit
      ? entry_t'{valid: 1'b1, tag: up_entry.tag,
                 ctr: up_taken ? sat_inc(up_entry.ctr) : sat_dec(up_entry.ctr),
                 target: up_taken ? up_target : up_entry.target}
      : entry_t'{valid: 1'b1, tag: up_tag, ctr: WT, target: up_target};
    // a not-taken miss leaves the entry alone; everything else accepted writes
    we = clearing || (acc && (up_hit || up_taken));
    wr_idx = clearing ? clr_idx_q : up_idx;
    wr_entry = clearing ? entry_t'{valid: 1'b0, tag: '0, ctr: INIT_CTR, target: '0} : upd_entry;
    clr_idx_d = clearing ? clr_idx_q + IDX_W'(1) : clr_idx_q;
    state_d = (clearing && clr_idx_q == IDX_W'(ENTRIES - 1)) ? RUN : state_q;
    stat_branches_d = acc ? sat_add32(stat_branches_q, 32'd1) : stat_branches_q;
    stat_mispredicts_d = (acc && up_mispredict) ? sat_add32(stat_mispredicts_q, 32'd1) : stat_mispredicts_q;
    pred_taken = ready && lu_entry.valid && lu_entry.tag == lu_tag && lu_entry.ctr[1];
    pred_target = pred_taken ? lu_entry.target : lu_pc + 32'd4;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= CLEAR;
      clr_idx_q <= '0;
      stat_branches_q <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      state_q <= state_d;
      clr_idx_q <= clr_idx_d;
      stat_branches_q <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end
endmodule
